// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Single-issue execution unit. It accepts one request at a time, computes
//   the ALU result, and holds the result until the consumer takes it. Most
//   operations finish in one cycle. The mul operation uses a shift-add loop
//   that always runs for exactly WIDTH cycles.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    request valid         in_ready   unit idle, can accept
//   opcode      3-bit opcode          func       4-bit R-type function
//   a, b        operands (b already extended for immediates)
//   out_valid   result valid          out_ready  consumer accepts result
//   result      registered result     zero       registered (result == 0)
//   illegal     registered, accepted opcode/func was undefined
//   dbg_state_o current FSM state (0 idle, 1 mul, 2 done)
//
// Handshake: a transfer occurs on a rising edge where valid and ready are
// both 1. in_ready is high only in IDLE, and out_valid is high only in DONE.
// While out_valid is high, result, zero and illegal do not change.
module alu_exec_unit #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [1:0]       dbg_state_o
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] a_q, b_q, acc_q;
  logic [WIDTH-1:0] result_q;
  logic             zero_q, illegal_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ill, is_mul;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] acc_d;

  assign shamt = b[SHW-1:0];

  // One-cycle decode and execute. It works on the live inputs because the
  // result is registered on the same edge that accepts the request.
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    is_mul  = 1'b0;
    case (opcode)
      3'b000: begin
        case (func)
          4'b0000: alu_res = a + b;
          4'b0001: alu_res = a - b;
          4'b0011: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
          4'b0100: alu_res = a & b;
          4'b0101: alu_res = a | b;
          4'b0110: alu_res = ~a;
          4'b0111: alu_res = a ^ b;
          4'b1000: alu_res = a << shamt;
          4'b1001: alu_res = a >> shamt;
          4'b1010: alu_res = $signed(a) >>> shamt;
          4'b1100: is_mul  = 1'b1;
          default: alu_ill = 1'b1;
        endcase
      end
      3'b001, 3'b011, 3'b100: alu_res = a + b;  // addi, st, ld address
      3'b010:                 alu_res = a - b;  // subi
      default:                alu_ill = 1'b1;
    endcase
  end

  // Each iteration adds one partial product: a shifted by the bit index,
  // used only where that bit of b is set.
  assign acc_d = acc_q + (b_q[cnt_q] ? (a_q << cnt_q) : '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q <= a;
            b_q <= b;
            if (is_mul) begin
              acc_q   <= '0;
              cnt_q   <= '0;
              state_q <= S_MUL;
            end else begin
              // An illegal op leaves alu_res at 0, so zero follows.
              result_q  <= alu_res;
              zero_q    <= (alu_res == '0);
              illegal_q <= alu_ill;
              state_q   <= S_DONE;
            end
          end
        end
        S_MUL: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == SHW'(WIDTH - 1)) begin
            result_q  <= acc_d;
            zero_q    <= (acc_d == '0);
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign result      = result_q;
  assign zero        = zero_q;
  assign illegal     = illegal_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   opcode = '0;
  logic [3:0]   func = '0;
  logic [W-1:0] a = '0, b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero, illegal;
  logic [1:0]   dbg_state;

  int checks = 0;
  int failures = 0;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .func(func), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Returns {result, zero, illegal} and the extra latency in cycles.
  function automatic void model(input logic [2:0] op, input logic [3:0] fn,
                                input logic [W-1:0] x, input logic [W-1:0] y,
                                output logic [W+1:0] word, output int lat);
    logic [W-1:0] r;
    logic         ill;
    int           sh;
    longint       prod;
    r = '0; ill = 1'b0; lat = 0;
    sh = int'(y) % W;
    if (op == 3'b000) begin
      case (fn)
        4'b0000: r = x + y;
        4'b0001: r = x - y;
        4'b0011: r = ($signed(x) < $signed(y)) ? 1 : 0;
        4'b0100: r = x & y;
        4'b0101: r = x | y;
        4'b0110: r = ~x;
        4'b0111: r = x ^ y;
        4'b1000: r = x << sh;
        4'b1001: r = x >> sh;
        4'b1010: r = $signed(x) >>> sh;
        4'b1100: begin
          prod = longint'(x) * longint'(y);
          r = prod[W-1:0];
          lat = W;
        end
        default: ill = 1'b1;
      endcase
    end else if (op == 3'b001 || op == 3'b011 || op == 3'b100) r = x + y;
    else if (op == 3'b010) r = x - y;
    else ill = 1'b1;
    word = {r, (r == '0), ill};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [W+1:0] exp_q[$];
  logic         enable = 1'b0;
  logic         pend = 1'b0;
  int           cyc = 0;
  int           due = 0;

  always @(negedge clk) begin
    logic         exp_ov;
    logic [W+1:0] w;
    int           lat;
    if (enable) begin
      cyc++;
      exp_ov = pend && (cyc >= due);
      check("out_valid_cycle", out_valid, exp_ov);
      check("in_ready_cycle", in_ready, !pend);
      if (out_valid && exp_ov && exp_q.size() > 0)
        check("result_word", {result, zero, illegal}, exp_q[0]);
      if (!rst_n) begin
        pend = 1'b0;
        exp_q.delete();
      end else if (pend) begin
        if (exp_ov && out_ready) begin
          pend = 1'b0;
          void'(exp_q.pop_front());
        end
      end else if (in_valid) begin
        model(opcode, func, a, b, w, lat);
        exp_q.push_back(w);
        pend = 1'b1;
        due = cyc + 1 + lat;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [2:0] op, input logic [3:0] fn,
                      input logic [W-1:0] x, input logic [W-1:0] y);
    logic was_ready;
    int   n;
    opcode = op; func = fn; a = x; b = y; in_valid = 1'b1;
    n = 0;
    do begin
      was_ready = in_ready;
      tick();
      n++;
    end while (!was_ready && n < 100);
    if (!was_ready) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) check("wait_out_timeout", 0, 1);
  endtask

  task automatic recv();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [3:0] fn,
                        input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [W-1:0] exp_r, input logic exp_ill, input int exp_lat);
    int n;
    send(op, fn, x, y);
    wait_out(n);
    check({name, "_lat"}, n, exp_lat);
    check({name, "_res"}, result, exp_r);
    check({name, "_zero"}, zero, (exp_r == '0));
    check({name, "_ill"}, illegal, exp_ill);
    recv();
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [3:0]   fn;
    logic [W-1:0] x, y, r;
    logic         ill;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int seen;
    // Reset held for two cycles.
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 16'h0000);
    check("rst_illegal", illegal, 0);
    check("rst_zero", zero, 0);
    enable = 1'b1;

    run_op("add_wrap", 3'b000, 4'b0000, 16'h7FFF, 16'h0001, 16'h8000, 0, 0);
    run_op("sub_wrap", 3'b000, 4'b0001, 16'h0000, 16'h0001, 16'hFFFF, 0, 0);
    run_op("slt_neg",  3'b000, 4'b0011, 16'hFFFF, 16'h0001, 16'h0001, 0, 0);
    run_op("sra_3",    3'b000, 4'b1010, 16'h8000, 16'h0013, 16'hF000, 0, 0);

    vecs.push_back('{3'b000, 4'b0100, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0});
    vecs.push_back('{3'b000, 4'b0101, 16'hF000, 16'h000F, 16'hF00F, 1'b0});
    vecs.push_back('{3'b000, 4'b0110, 16'h00FF, 16'h1234, 16'hFF00, 1'b0});
    vecs.push_back('{3'b000, 4'b0111, 16'hAAAA, 16'hFFFF, 16'h5555, 1'b0});
    vecs.push_back('{3'b000, 4'b1000, 16'h0001, 16'h0024, 16'h0010, 1'b0});
    vecs.push_back('{3'b000, 4'b1001, 16'h8000, 16'h000F, 16'h0001, 1'b0});
    vecs.push_back('{3'b000, 4'b1010, 16'h4000, 16'h0001, 16'h2000, 1'b0});
    vecs.push_back('{3'b000, 4'b0011, 16'h0001, 16'hFFFF, 16'h0000, 1'b0});
    vecs.push_back('{3'b001, 4'b1111, 16'hFFFF, 16'h0001, 16'h0000, 1'b0});
    vecs.push_back('{3'b010, 4'b0000, 16'h0005, 16'h0003, 16'h0002, 1'b0});
    vecs.push_back('{3'b011, 4'b0000, 16'h1000, 16'h0020, 16'h1020, 1'b0});
    vecs.push_back('{3'b100, 4'b0000, 16'h0100, 16'hFF00, 16'h0000, 1'b0});
    vecs.push_back('{3'b000, 4'b0010, 16'h1234, 16'h5678, 16'h0000, 1'b1});
    vecs.push_back('{3'b101, 4'b0000, 16'h1234, 16'h5678, 16'h0000, 1'b1});
    vecs.push_back('{3'b111, 4'b0000, 16'h1111, 16'h2222, 16'h0000, 1'b1});
    foreach (vecs[i])
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].fn, vecs[i].x, vecs[i].y,
             vecs[i].r, vecs[i].ill, 0);

    // Multiply, then hold the result under back-pressure with a new request pending.
    send(3'b000, 4'b1100, 16'h0123, 16'h0010);
    wait_out(seen);
    check("mul_lat", seen, W);
    check("mul_res", result, 16'h1230);
    opcode = 3'b000; func = 4'b0000; a = 16'h0001; b = 16'h0001; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_res", result, 16'h1230);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    recv();
    check("post_xfer_in_ready", in_ready, 1);
    check("post_xfer_out_valid", out_valid, 0);
    tick(); tick();
    check("no_queued_req", out_valid, 0);

    run_op("mul_zero", 3'b000, 4'b1100, 16'h0000, 16'h1234, 16'h0000, 0, W);
    run_op("mul_ff",   3'b000, 4'b1100, 16'hFFFF, 16'hFFFF, 16'h0001, 0, W);
    run_op("mul_mix",  3'b000, 4'b1100, 16'h00FF, 16'h0101, 16'hFFFF, 0, W);

    // Reset aborts an in-flight mul.
    send(3'b000, 4'b1100, 16'h0003, 16'h0005);
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("abort_never_valid", seen, 0);

    // Reset takes priority over a request in the same cycle.
    send(3'b000, 4'b0000, 16'h0002, 16'h0002);
    recv();
    opcode = 3'b000; func = 4'b0000; a = 16'h0004; b = 16'h0004; in_valid = 1'b1;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    in_valid = 1'b0;
    check("rst_prio_out_valid", out_valid, 0);
    check("rst_prio_result", result, 16'h0000);
    tick();
    check("rst_prio_idle", in_ready, 1);

    run_op("final_add", 3'b000, 4'b0000, 16'h1234, 16'h1111, 16'h2345, 0, 0);
    tick();
    enable = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH, default 16, datapath width; SHALL be a power of two, at least 4.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  request valid.
REQ-005 in_ready  output  1  unit can accept a request.
REQ-006 opcode  input  3  instruction opcode.
REQ-007 func  input  4  R-type function field.
REQ-008 a  input  WIDTH  operand A (rs).
REQ-009 b  input  WIDTH  operand B (rt or immediate, pre-extended).
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  registered result.
REQ-013 zero  output  1  registered, high when result equals 0.
REQ-014 illegal  output  1  registered, high when the accepted opcode/func is undefined.

Function
REQ-015 Decode, opcode 000 by func: 0000 add, 0001 sub, 0011 slt, 0100 and, 0101 or, 0110 not (~a, b ignored), 0111 xor, 1000 sll, 1001 srl, 1010 sra, 1100 mul.
REQ-016 Decode by opcode: 001 addi=add, 010 subi=sub, 011 st=add, 100 ld=add (address generation).
REQ-017 Any other opcode, or opcode 000 with an unlisted func, SHALL be illegal: result 0, zero 1, illegal 1.
REQ-018 add/sub SHALL wrap modulo 2^WIDTH; no carry/overflow output.
REQ-019 slt SHALL compare a and b as signed two's complement; result 1 if a<b, else 0.
REQ-020 Shifts SHALL shift a by b[log2(WIDTH)-1:0]; upper bits of b ignored; sra fills with a[WIDTH-1].
REQ-021 mul SHALL return low WIDTH bits of unsigned a*b, computed iteratively by shift-add, one partial product per cycle.
REQ-022 FSM states: IDLE, MUL, DONE.
REQ-023 in_ready SHALL be 1 only in IDLE; request accepted in cycle N when in_valid and in_ready are both 1.
REQ-024 On acceptance, opcode, func, a and b SHALL be latched; input changes after acceptance SHALL have no effect.
REQ-025 Non-mul op accepted in cycle N: result/zero/illegal registered and state DONE, out_valid high from cycle N+1.
REQ-026 mul accepted in cycle N: state MUL for exactly WIDTH cycles, iteration counter 0..WIDTH-1, then DONE; out_valid high from cycle N+1+WIDTH.
REQ-027 out_valid SHALL be 1 only in DONE; result, zero and illegal SHALL stay stable while out_valid=1 and out_ready=0.
REQ-028 In DONE, out_ready=1 SHALL complete the transfer and return the FSM to IDLE next cycle; at most one request per two cycles.
REQ-029 In_valid in MUL or DONE SHALL be ignored; no request queueing.
REQ-030 mul with a or b equal 0 SHALL still take WIDTH cycles (fixed latency).

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, counter 0, result 0, zero 0, illegal 0, out_valid 0; in_ready 1 next cycle.
REQ-032 Reset during MUL or DONE SHALL abort the operation; the pending result is discarded and never presented.
REQ-033 Reset SHALL take priority over a request presented in the same cycle.

Verification (WIDTH=16)
REQ-034 Hold rst_n=0 two cycles, release -> out_valid=0, in_ready=1, result=0x0000, illegal=0.
REQ-035 op 000/func 0000, a=0x7FFF, b=0x0001 -> next cycle out_valid=1, result=0x8000, zero=0; then op 000/func 0001, a=0x0000, b=0x0001 -> result=0xFFFF.
REQ-036 op 000/func 0011, a=0xFFFF, b=0x0001 -> result=0x0001; func 1010, a=0x8000, b=0x0013 -> result=0xF000 (shift 3).
REQ-037 op 000/func 1100, a=0x0123, b=0x0010 accepted cycle N -> in_ready=0 and out_valid=0 cycles N+1..N+16, out_valid=1 with result=0x1230 at N+17.
REQ-038 Result 0x1230 held with out_ready=0 for 5 cycles and in_valid=1 with new operands -> result unchanged, in_ready=0, new request never executed; out_ready=1 -> IDLE next cycle.
REQ-039 opcode 111 -> result=0x0000, zero=1, illegal=1 after one cycle; rst_n=0 at cycle N+5 of a mul -> out_valid never asserts for it, in_ready=1 after reset.
